// File: rtl/counter_pkg.sv
// counter_pkg: shared state and direction encodings for param_counter
package counter_pkg;
  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;
  localparam logic DIR_UP  = 1'b1;
  localparam logic DIR_DN  = 1'b0;
endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: emits a tick every prescale+1 enabled cycles
module cnt_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);
  logic [PRE_W-1:0] pre_q, pre_d;
  assign tick = en && (pre_q == prescale);
  always_comb pre_d = clr ? '0 : !en ? pre_q : tick ? '0 : pre_q + 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) pre_q <= '0;
    else pre_q <= pre_d;
endmodule

// File: rtl/param_counter.sv
// param_counter: loadable up/down modulus counter with prescaler, one-shot/wrap modes
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cnt_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             oneshot,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             match
);
  logic [WIDTH-1:0] count_q, count_d;
  logic st_q, st_d, tc_q, tc_d, done_q, done_d;
  logic tick, at_term;
  // load outranks the prescaler, so it is kept out of the prescaler's enable
  cnt_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ena && cnt_en && !load && st_q == ST_RUN),
    .clr     (ena && load),
    .prescale(prescale),
    .tick    (tick)
  );
  assign at_term = (dir == DIR_UP) ? (count_q >= limit) : (count_q == '0);
  always_comb begin
    count_d = count_q;
    st_d    = st_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (ena && load) begin
      count_d = load_val;
      st_d    = ST_RUN;
      done_d  = 1'b0;
    end else if (ena && st_q == ST_RUN && tick) begin
      tc_d    = at_term;
      count_d = !at_term ? ((dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1)
              : oneshot ? count_q : (dir == DIR_UP) ? '0 : limit;
      st_d    = (at_term && oneshot) ? ST_HALT : ST_RUN;
      done_d  = at_term && oneshot;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      count_q <= '0;
      st_q    <= ST_RUN;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      st_q    <= st_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign match = (count_q == cmp_val);
endmodule

// File: doc/param_counter.md
# param_counter

Parametrised loadable up/down counter core: the next generation of the team's 8-bit free-running loadable counter. It adds direction control, a programmable terminal value (modulus), a rate prescaler, one-shot/wrap modes, a terminal-count pulse and a compare-match flag. The Tiny Tapeout top wrapper instantiates it with `WIDTH=8` and maps its ports onto `ui_in`/`uio_in`/`uo_out`. All outputs are always driven; there is no tri-state.

## Interface
- `WIDTH`, default 8: counter, load, limit and compare width.
- `PRE_W`, default 4: prescaler field width. The count rate is divided by `prescale+1`.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `ena`, input, 1: global enable. When low, all state holds, including the prescaler.
- `cnt_en`, input, 1: count enable. When low, counting and the prescaler hold.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: load value.
- `dir`, input, 1: 1 = up, 0 = down.
- `limit`, input, WIDTH: terminal value. The count range is 0..`limit`.
- `oneshot`, input, 1: 1 = halt at the terminal value, 0 = wrap.
- `prescale`, input, PRE_W: a count tick occurs every `prescale+1` enabled cycles.
- `cmp_val`, input, WIDTH: compare value.
- `count`, output, WIDTH: current count (registered).
- `tc`, output, 1: terminal-count pulse, one cycle wide (registered).
- `done`, output, 1: one-shot finished, level (registered).
- `match`, output, 1: combinational `count == cmp_val`.

## Operation
- State machine `st` has two states:
  - RUN: the counter advances on each tick.
  - HALT: the one-shot has completed; the count is frozen.
- Priority in each cycle, highest first:
  1. `!rst_n`
  2. `!ena`
  3. `load`
  4. HALT
  5. tick
- Reset sets `count=0`, `pre_cnt=0`, `tc=0`, `done=0`, `st=RUN`.
- While `!ena`, every register holds and `tc` is forced to 0.
- `load` (with `ena`):
  - sets `count<=load_val`, `pre_cnt<=0`, `st<=RUN`, `done<=0`, `tc<=0`;
  - is independent of `cnt_en`.
- Prescaler, when `ena && cnt_en && st==RUN`:
  - if `pre_cnt==prescale`, then tick=1 and `pre_cnt<=0`;
  - otherwise `pre_cnt<=pre_cnt+1`.
  - `prescale=0` gives a tick every enabled cycle.
- Terminal condition:
  - up: `count >= limit` (covers a load above `limit`);
  - down: `count == 0`.
- On a tick when not at terminal: `count <= count ± 1` (modulo 2^WIDTH is never reached because of the terminal check).
- On a tick at terminal, `tc<=1`, then:
  - wrap mode: up loads 0, down loads `limit`;
  - one-shot mode: `count` holds, `st<=HALT`, `done<=1`.
- `tc` is 0 in every cycle other than a terminal tick.
- HALT is left only by `load` or reset. Clearing `oneshot` while halted does not resume counting.
- Changing `dir`, `limit` or `prescale` mid-count takes effect at the next cycle's evaluation. No resynchronisation.
- `limit=0`: up and down both reach terminal on every tick; `tc` fires on every tick and `count` stays 0.

## Timing
- `count`, `tc` and `done` change only at the `clk` edge after the qualifying cycle:
  - load-to-`count` latency is 1 cycle;
  - tick-to-`count` latency is 1 cycle.
- `tc` and the wrap (or entry to HALT) appear in the same cycle.
- `match` follows `count` combinationally, with 0 added latency.
- With `prescale=P`, consecutive `count` changes are `P+1` enabled cycles apart.
- Reset asserted mid-count or mid-HALT takes effect at the next edge. It overrides a simultaneous `load`.

## Structure
- Shared package `counter_pkg`:
  - state encodings `ST_RUN=1'b0`, `ST_HALT=1'b1`;
  - direction constants `DIR_UP=1'b1`, `DIR_DN=1'b0`.
- Sub-module `cnt_prescaler`:
  - parameter `PRE_W`;
  - inputs `clk`, `rst_n`, `en`, `clr`, `prescale`;
  - output `tick`.
  - `clr` is driven by `load`.
- The core holds the count register, the FSM and the terminal logic. `match` is a single comparator in the core.

## Test plan
- Reset, then `ena=1`, `cnt_en=1`, `dir=1`, `limit=5`, `prescale=0`, `oneshot=0`, run 14 cycles:
  - `count` goes 0,1,2,3,4,5,0,1…;
  - `tc` is high exactly in the cycles where `count` goes 5→0.
- Down wrap with `limit=9`, after loading `load_val=2`:
  - `count` goes 2,1,0,9,8;
  - one `tc` pulse at 0→9.
- One-shot up, `limit=3`, from 0:
  - `count` reaches 3 and stays;
  - `tc` pulses once, `done=1`;
  - further cycles leave `count=3`;
  - `load` with `load_val=1` clears `done` and resumes counting.
- `prescale=2`, up from 0:
  - `count` increments every 3rd cycle;
  - with `cmp_val=2`, `match` is high only while `count==2`.
- Priority and boundary cases:
  - `load` (with `load_val=0xA0`) together with a tick: `count=0xA0`;
  - with `limit=0x10`, the next tick gives `count=0` and `tc=1`;
  - `ena=0` for 4 cycles freezes `count` and the prescaler;
  - `rst_n=0` for one cycle during counting gives `count=0`, `done=0` on the next edge.
